lsu_store_tracker: RTL and testbench
====================================

# lsu_store_tracker

Parametrised tracker for stores that have been dispatched to the LSU but not yet committed. It sits between dispatch/decode and the LSU, and is the multi-channel successor to the single-counter store lock. It counts in-flight stores across DISPATCH_WIDTH reservation-station slots and COMMIT_WIDTH commit ports, and drives the load-issue lock plus a dispatch back-pressure flag. It also runs a drain state machine that acknowledges SYNC/fence requests once every store has left the pipeline and the store buffer.

## Interface
Parameters:
- DISPATCH_WIDTH, 2, number of reservation-station slots inspected per cycle.
- COMMIT_WIDTH, 2, number of commit-store strobes per cycle.
- DEPTH, `ROB_SIZE, maximum legal in-flight store count.
- HEADROOM, DISPATCH_WIDTH, `almost_full` asserts when count ≥ DEPTH − HEADROOM.

Ports:
- clk  in  1  clock; single clock domain, all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  pipeline flush; synchronous.
- lsu_store_empty  in  1  LSU store buffer empty.
- rs  in  [DISPATCH_WIDTH-1:0] reserve_station_t  dispatched entries this cycle.
- commit_store  in  COMMIT_WIDTH  one strobe per committed store.
- sync_req  in  1  single-cycle pulse: a SYNC/fence was dispatched.
- locked  out  1  loads must not issue.
- almost_full  out  1  dispatch must stall new stores.
- store_count  out  $clog2(DEPTH)+1  current in-flight count.
- sync_ack  out  1  one-cycle pulse: drain complete.
- err  out  1  sticky overflow/underflow flag.

## Operation
- Slot i counts as a dispatched store when rs[i].busy && rs[i].decoded.fu == FU_STORE.
- inc = popcount of dispatched stores; dec = popcount(commit_store).
- Width rule: compute sum = count + inc − dec in $clog2(DEPTH)+3 bits, signed.
  - sum > DEPTH: count ← DEPTH, err ← 1.
  - sum < 0: count ← 0, err ← 1.
  - Otherwise count ← sum.
- flush: count ← 0 and the FSM goes to IDLE. Flush wins over same-cycle dispatch, commit and sync_req. err is not cleared by flush.
- locked = (count != 0) | ~lsu_store_empty | (state != IDLE).
- almost_full = (count ≥ DEPTH − HEADROOM).
- FSM states are IDLE, DRAIN and DONE.
  - IDLE → DRAIN on sync_req.
  - DRAIN → DONE when the registered count == 0 && lsu_store_empty.
  - DONE → IDLE unconditionally.
  - sync_req while in DRAIN is absorbed and does not restart the drain.
  - sync_req while in DONE is dropped; decode never issues back-to-back SYNCs.
- sync_ack = (state == DONE).
- Reset values: count = 0, state = IDLE, err = 0. Outputs after reset: store_count = 0, sync_ack = 0, err = 0, almost_full = 0, and locked = ~lsu_store_empty.

## Timing
- The count is registered. A store dispatched in cycle t appears in store_count and locked at t+1. A commit in cycle t decrements at t+1.
- locked has a combinational path from lsu_store_empty. All other terms of locked come from registers.
- sync_req at t with count = 0 and the buffer empty gives DRAIN at t+1 and sync_ack = 1 in t+2 only.
- Minimum SYNC turnaround is therefore 2 cycles. The drain waits as long as required; there is no timeout.
- Asynchronous rst mid-drain: state → IDLE immediately. No sync_ack is emitted, and the outputs take their reset values within the same cycle.
- Flush in DRAIN or DONE: IDLE at the next edge. No sync_ack is emitted that cycle or afterwards.

## Structure
- Existing shared types come from the shared defs header: reserve_station_t, FU_STORE and `ROB_SIZE.
- Add lsu_sync_state_t (IDLE/DRAIN/DONE enum) to the shared package; the ROB and the debug monitor decode it.
- One sub-module: popcount, parametrised on width. It is instantiated twice, once for dispatch and once for commit.

## Test plan
- Reset with lsu_store_empty = 1 → locked = 0, store_count = 0. Then dispatch 2 stores in one cycle → store_count = 2 and locked = 1 next cycle. Commit both in one cycle → count = 0 and locked = 0.
- With count = 3, one cycle carrying 1 dispatch store, 1 non-store busy slot and 2 commits → count = 2.
- With DEPTH = 16 and count = 15, dispatch 2 stores → count = 16, err = 1 permanently, almost_full = 1. From count = 0, a commit → count stays 0 and err = 1.
- sync_req with count = 2 and store buffer non-empty → DRAIN persists. Commit both, then lsu_store_empty rises → sync_ack is a single-cycle pulse 1 cycle later, then IDLE.
- Flush while in DRAIN with count = 5, in the same cycle as a dispatch → count = 0, state = IDLE, no sync_ack ever.
- Assert rst mid-cycle during DRAIN → state, count and sync_ack clear immediately without waiting for a clock edge.

Source files
------------

// File: rtl/lsu_store_tracker_pkg.sv
// Shared LSU/dispatch types: reservation-station entry, FU codes, sync FSM state.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.

`ifndef ROB_SIZE
`define ROB_SIZE 16
`endif

package lsu_store_tracker_pkg;

   // Functional-unit class carried by a decoded instruction
   typedef enum logic [1:0] {
      FU_ALU    = 2'd0,
      FU_LOAD   = 2'd1,
      FU_STORE  = 2'd2,
      FU_BRANCH = 2'd3
   } fu_t;

   typedef struct packed {
      fu_t fu;
   } decoded_t;

   typedef struct packed {
      logic     busy;
      decoded_t decoded;
   } reserve_station_t;

   // Drain FSM state; also decoded by the ROB and the debug monitor
   typedef enum logic [1:0] {
      LSU_SYNC_IDLE  = 2'd0,
      LSU_SYNC_DRAIN = 2'd1,
      LSU_SYNC_DONE  = 2'd2
   } lsu_sync_state_t;

   // A slot is a dispatched store only when it is occupied and targets the store unit
   function automatic logic rs_is_store(input reserve_station_t e);
      return e.busy && (e.decoded.fu == FU_STORE);
   endfunction

endpackage

// File: rtl/lsu_store_tracker_popcount.sv
// Population count of a strobe vector.
// Latency: combinational.
// Backpressure: none.

module lsu_store_tracker_popcount #(
   parameter int  WIDTH = 2,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] i_bits,
   output logic [CNT_W-1:0] o_count
);

   // Sum the set bits; WIDTH is small so a linear adder chain is fine
   always_comb begin
      o_count = '0;
      for (int i = 0; i < WIDTH; i++) begin
         o_count = o_count + CNT_W'(i_bits[i]);
      end
   end

endmodule

// File: rtl/lsu_store_tracker.sv
// In-flight store tracker: drives the load-issue lock, dispatch almost-full and SYNC drain ack.
// Latency: count/state registered, visible one cycle after dispatch/commit; locked also
// combinational from lsu_store_empty. Backpressure: almost_full tells dispatch to stall stores.

module lsu_store_tracker
   import lsu_store_tracker_pkg::*;
#(
   parameter int  DISPATCH_WIDTH = 2,
   parameter int  COMMIT_WIDTH   = 2,
   parameter int  DEPTH          = `ROB_SIZE,
   parameter int  HEADROOM       = DISPATCH_WIDTH,
   localparam int CNT_W          = $clog2(DEPTH) + 1
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   flush,
   input  logic                                   lsu_store_empty,
   input  reserve_station_t [DISPATCH_WIDTH-1:0]  rs,
   input  logic [COMMIT_WIDTH-1:0]                commit_store,
   input  logic                                   sync_req,
   output logic                                   locked,
   output logic                                   almost_full,
   output logic [CNT_W-1:0]                       store_count,
   output logic                                   sync_ack,
   output logic                                   err
);

   // Sum carries two extra bits: one for headroom above DEPTH, one for sign
   localparam int SUM_W     = $clog2(DEPTH) + 3;
   localparam int INC_W     = $clog2(DISPATCH_WIDTH + 1);
   localparam int DEC_W     = $clog2(COMMIT_WIDTH + 1);
   localparam int AF_THRESH = (DEPTH > HEADROOM) ? (DEPTH - HEADROOM) : 0;

   localparam logic signed [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);
   localparam logic [CNT_W-1:0]        DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]        AF_C    = CNT_W'(AF_THRESH);

   logic [CNT_W-1:0]           r_count;
   logic                       r_err;
   lsu_sync_state_t            r_state;

   logic [DISPATCH_WIDTH-1:0]  w_disp_vec;
   logic [INC_W-1:0]           w_inc;
   logic [DEC_W-1:0]           w_dec;
   logic signed [SUM_W-1:0]    w_sum;
   logic [CNT_W-1:0]           w_count_nxt;
   logic                       w_err_set;
   lsu_sync_state_t            w_state_nxt;

   // Flag which reservation-station slots hold a newly dispatched store
   always_comb begin
      w_disp_vec = '0;
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
         w_disp_vec[i] = rs_is_store(rs[i]);
      end
   end

   lsu_store_tracker_popcount #(
      .WIDTH   (DISPATCH_WIDTH)
   ) u_pop_disp (
      .i_bits  (w_disp_vec),
      .o_count (w_inc)
   );

   lsu_store_tracker_popcount #(
      .WIDTH   (COMMIT_WIDTH)
   ) u_pop_commit (
      .i_bits  (commit_store),
      .o_count (w_dec)
   );

   assign w_sum = $signed(SUM_W'(r_count)) + $signed(SUM_W'(w_inc))
                - $signed(SUM_W'(w_dec));

   // Next count: flush dominates, otherwise saturate at [0, DEPTH] and flag the violation
   always_comb begin
      w_count_nxt = r_count;
      w_err_set   = 1'b0;
      if (flush) begin
         w_count_nxt = '0;
      end else if (w_sum > DEPTH_S) begin
         w_count_nxt = DEPTH_C;
         w_err_set   = 1'b1;
      end else if (w_sum[SUM_W-1]) begin
         w_count_nxt = '0;
         w_err_set   = 1'b1;
      end else begin
         w_count_nxt = w_sum[CNT_W-1:0];
      end
   end

   // Drain FSM next state; a sync_req outside IDLE is ignored
   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = LSU_SYNC_IDLE;
      end else begin
         case (r_state)
            LSU_SYNC_IDLE: begin
               if (sync_req) w_state_nxt = LSU_SYNC_DRAIN;
            end
            LSU_SYNC_DRAIN: begin
               if ((r_count == '0) && lsu_store_empty) w_state_nxt = LSU_SYNC_DONE;
            end
            LSU_SYNC_DONE: begin
               w_state_nxt = LSU_SYNC_IDLE;
            end
            default: begin
               w_state_nxt = LSU_SYNC_IDLE;
            end
         endcase
      end
   end

   // Count, sticky error and FSM state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
         r_err   <= 1'b0;
         r_state <= LSU_SYNC_IDLE;
      end else begin
         r_count <= w_count_nxt;
         r_err   <= r_err | w_err_set;
         r_state <= w_state_nxt;
      end
   end

   // Loads wait while stores are tracked, the buffer holds data, or a drain is in progress
   assign locked      = (r_count != '0) | ~lsu_store_empty | (r_state != LSU_SYNC_IDLE);
   assign almost_full = (r_count >= AF_C);
   assign store_count = r_count;
   assign sync_ack    = (r_state == LSU_SYNC_DONE);
   assign err         = r_err;

endmodule

// File: tb/tb_lsu_store_tracker.sv
// Directed bench for lsu_store_tracker with hand-computed expectations.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a.

module tb_lsu_store_tracker;
   import lsu_store_tracker_pkg::*;

   localparam int DW    = 2;
   localparam int CMW   = 2;
   localparam int DEPTH = 16;
   localparam int HR    = 2;
   localparam int SCW   = $clog2(DEPTH) + 1;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      flush;
   logic                      lsu_store_empty;
   reserve_station_t [DW-1:0] rs;
   logic [CMW-1:0]            commit_store;
   logic                      sync_req;
   logic                      locked;
   logic                      almost_full;
   logic [SCW-1:0]            store_count;
   logic                      sync_ack;
   logic                      err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   lsu_store_tracker #(
      .DISPATCH_WIDTH (DW),
      .COMMIT_WIDTH   (CMW),
      .DEPTH          (DEPTH),
      .HEADROOM       (HR)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .lsu_store_empty (lsu_store_empty),
      .rs              (rs),
      .commit_store    (commit_store),
      .sync_req        (sync_req),
      .locked          (locked),
      .almost_full     (almost_full),
      .store_count     (store_count),
      .sync_ack        (sync_ack),
      .err             (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic reserve_station_t mk(input logic busy, input fu_t fu);
      reserve_station_t e;
      e            = '0;
      e.busy       = busy;
      e.decoded.fu = fu;
      return e;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Dispatch n stores (0..2) for one cycle
   task automatic dispatch(input int n);
      rs[0] = (n > 0) ? mk(1'b1, FU_STORE) : mk(1'b0, FU_ALU);
      rs[1] = (n > 1) ? mk(1'b1, FU_STORE) : mk(1'b0, FU_ALU);
      tick;
      rs = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; lsu_store_empty = 1'b1; sync_req = 1'b0;
      commit_store = '0; rs = '0;
      #2;
      check("rst_count",  store_count, 0);
      check("rst_locked", locked, 0);
      check("rst_ack",    sync_ack, 0);
      check("rst_err",    err, 0);
      check("rst_af",     almost_full, 0);
      lsu_store_empty = 1'b0;
      #1;
      check("rst_locked_nempty", locked, 1);
      lsu_store_empty = 1'b1;
      #9 rst = 1'b0;

      // Two stores in one cycle, then two commits in one cycle
      dispatch(2);
      check("disp2_count",  store_count, 2);
      check("disp2_locked", locked, 1);
      commit_store = 2'b11; tick; commit_store = '0;
      check("com2_count",  store_count, 0);
      check("com2_locked", locked, 0);

      // Mixed cycle: 1 store, 1 busy load, 2 commits from count 3
      dispatch(2); dispatch(1);
      check("build3", store_count, 3);
      rs[0] = mk(1'b1, FU_STORE); rs[1] = mk(1'b1, FU_LOAD); commit_store = 2'b11;
      tick;
      rs = '0; commit_store = '0;
      check("mix_count", store_count, 2);
      rs[0] = mk(1'b0, FU_STORE); rs[1] = mk(1'b1, FU_STORE);
      tick;
      rs = '0;
      check("notbusy_count", store_count, 3);
      commit_store = 2'b11; tick; commit_store = 2'b01; tick; commit_store = '0;
      check("drain_to0", store_count, 0);

      // Minimum-latency SYNC
      sync_req = 1'b1; tick; sync_req = 1'b0;
      check("fsync_drain_ack",    sync_ack, 0);
      check("fsync_drain_locked", locked, 1);
      tick;
      check("fsync_done_ack", sync_ack, 1);
      tick;
      check("fsync_idle_ack",    sync_ack, 0);
      check("fsync_idle_locked", locked, 0);

      // Drain waits for commits and an empty store buffer
      dispatch(2);
      lsu_store_empty = 1'b0;
      sync_req = 1'b1; tick; sync_req = 1'b0;
      check("drain_ack0", sync_ack, 0);
      sync_req = 1'b1; tick; sync_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         check("drain_wait_ack", sync_ack, 0);
      end
      commit_store = 2'b11; tick; commit_store = '0;
      check("drain_cnt0",    store_count, 0);
      check("drain_ack_cnt0", sync_ack, 0);
      check("drain_locked",  locked, 1);
      tick;
      check("drain_nempty_ack", sync_ack, 0);
      lsu_store_empty = 1'b1;
      tick;
      check("drain_done_ack", sync_ack, 1);
      tick;
      check("drain_pulse_end", sync_ack, 0);
      check("drain_idle_locked", locked, 0);

      // Flush during DRAIN with count 5 and a same-cycle dispatch
      lsu_store_empty = 1'b0;
      dispatch(2); dispatch(2); dispatch(1);
      check("fl_count5", store_count, 5);
      sync_req = 1'b1; tick; sync_req = 1'b0;
      check("fl_pre_ack", sync_ack, 0);
      flush = 1'b1; rs[0] = mk(1'b1, FU_STORE); rs[1] = mk(1'b1, FU_STORE);
      tick;
      flush = 1'b0; rs = '0;
      check("fl_count", store_count, 0);
      check("fl_ack",   sync_ack, 0);
      lsu_store_empty = 1'b1;
      #1;
      check("fl_idle_locked", locked, 0);
      for (int i = 0; i < 3; i++) begin
         tick;
         check("fl_no_ack", sync_ack, 0);
      end

      // Almost-full boundary and overflow saturation
      for (int i = 0; i < 6; i++) dispatch(2);
      dispatch(1);
      check("af13_count", store_count, 13);
      check("af13",       almost_full, 0);
      dispatch(1);
      check("af14", almost_full, 1);
      dispatch(1);
      check("pre_ovf_count", store_count, 15);
      check("pre_ovf_err",   err, 0);
      dispatch(2);
      check("ovf_count", store_count, 16);
      check("ovf_err",   err, 1);
      check("ovf_af",    almost_full, 1);
      tick;
      check("ovf_err_sticky", err, 1);
      dispatch(1);
      check("ovf_sat", store_count, 16);
      flush = 1'b1; tick; flush = 1'b0;
      check("flush_count",   store_count, 0);
      check("flush_keeps_err", err, 1);
      check("flush_af",      almost_full, 0);

      // Asynchronous reset in the middle of a drain
      dispatch(2); dispatch(1);
      lsu_store_empty = 1'b0;
      sync_req = 1'b1; tick; sync_req = 1'b0;
      check("arst_pre_count", store_count, 3);
      #3 rst = 1'b1;
      #1;
      check("arst_count",  store_count, 0);
      check("arst_err",    err, 0);
      check("arst_ack",    sync_ack, 0);
      check("arst_locked", locked, 1);
      lsu_store_empty = 1'b1;
      #1;
      check("arst_idle_locked", locked, 0);
      #1 rst = 1'b0;
      tick;
      check("arst_post_ack", sync_ack, 0);

      // Underflow from zero sets err and holds count at 0
      commit_store = 2'b10; tick; commit_store = '0;
      check("unf_count", store_count, 0);
      check("unf_err",   err, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
